dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
// - Data-memory responder for the processor store interface (MemWrite/DataAdr/WriteData).
// - Stores are queued in a small FIFO and retired into a word-addressed RAM whenever the memory
//   port is free (drain_ok); loads see the youngest value, whether it is still buffered or already in RAM.
// - Sits between the MIPS core and data memory inside top; the core stalls only when the buffer is full.
// PARAMETERS
// - DATA_W     32     data word width
// - MEM_WORDS  64     RAM depth in words (power of 2); AW = $clog2(MEM_WORDS)
// - BUF_DEPTH  4      store-buffer entries (power of 2, >=2)
// - TRAP_ADDR  32'h64 byte address watched by the optional done trap
// - TRAP_VAL   32'd7  value that fires the done trap
// PORTS
// - clk         in   1       rising-edge clock
// - reset_n     in   1       asynchronous, active-low reset
// - MemWrite    in   1       store request from core
// - DataAdr     in   32      byte address for load/store
// - WriteData   in   DATA_W  store data
// - ReadData    out  DATA_W  load data (combinational)
// - drain_ok    in   1       memory port free this cycle; head entry may retire
// - stall       out  1       buffer full; the store on MemWrite is not accepted
// - buf_empty   out  1       no pending stores
// - done        out  1       sticky trap flag (DONE_TRAP_EN only, else tied 0)
// BEHAVIOUR
// - Word index = DataAdr[AW+1:2]. Bits [1:0] are ignored, and bits above AW+1 alias (wrap).
// - Reset (async assert, sync release): wr_ptr=rd_ptr=count=0, stall=0, buf_empty=1, done=0.
//   RAM contents are not reset. Reset mid-operation discards all pending entries.
// - stall = (count==BUF_DEPTH), purely from registered count.
//   A freeing drain in the same cycle does not lower stall.
// - Enqueue: at posedge when MemWrite && !stall, push {index,WriteData}; wr_ptr wraps modulo BUF_DEPTH.
//   MemWrite while stall: ignored; the core holds the request.
// - Drain: at posedge when drain_ok && count!=0, RAM[head.index] <= head.data; rd_ptr wraps.
//   Exactly one entry retires per cycle, in order.
// - Simultaneous enqueue+drain: count unchanged. Enqueue into empty buffer + drain_ok: not
//   retired the same cycle (drains next cycle at earliest).
// - Store latency: accepted store visible on ReadData the same cycle after its posedge (forwarding);
//   it reaches RAM at the first drain_ok cycle once it is head.
// - ReadData: youngest valid buffer entry whose index matches, else RAM[index].
//   Stores are not coalesced; duplicate indices may be queued.
// - buf_empty = (count==0).
// CONFIGURATION
// - DONE_TRAP_EN defined: done sets at the posedge on which an entry with byte address
//   TRAP_ADDR and data TRAP_VAL retires into RAM. done clears only on reset.
//   The entry also writes RAM normally.
// - DONE_TRAP_EN undefined: no trap logic; done is constant 0.
// STRUCTURE
// - dmem_pkg: typedef sb_entry_t {logic [AW-1:0] idx; logic [DATA_W-1:0] data;}; TRAP_ADDR/TRAP_VAL defaults.
// - Sub-module store_fifo: circular buffer with ptrs/count, push/pop, exposes all entries + valid mask for
//   the forwarding search; dmem_store_buffer adds RAM, forwarding mux, and trap.
// TESTING
// - Reset, then MemWrite 0x60<-5 with drain_ok=0 -> ReadData@0x60=5 next cycle, buf_empty=0, RAM[24] unchanged.
// - 4 stores 0x0,0x4,0x8,0xC (drain_ok=0) -> stall=1; a 5th store held 3 cycles is not accepted;
//   drain_ok=1 for 1 cycle -> stall=0, 5th store accepted.
// - Stores 0x10<-1 then 0x10<-2 buffered -> ReadData@0x10=2; drain one -> still 2; drain all -> RAM[4]=2.
// - Enqueue+drain in the same cycle with count=2 -> count stays 2; retire order matches store order.
// - reset_n pulsed low mid-cycle with 3 pending -> buf_empty=1 immediately, pending stores never reach RAM.
// - DONE_TRAP_EN: store 0x64<-7, then drain -> done=1 at that posedge and remains 1;
//   store 0x64<-6 -> done stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory store buffer.
// Optional feature macro: DONE_TRAP_EN (see dmem_store_buffer.sv).
package dmem_pkg;

  localparam int SB_DATA_W    = 32;
  localparam int SB_MEM_WORDS = 64;
  localparam int SB_AW        = $clog2(SB_MEM_WORDS);
  localparam int SB_BUF_DEPTH = 4;

  localparam logic [31:0] DEF_TRAP_ADDR = 32'h64;
  localparam logic [31:0] DEF_TRAP_VAL  = 32'd7;

  // One queued store: word index into the RAM plus the data to write there.
  typedef struct packed {
    logic [SB_AW-1:0]     idx;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_fifo.sv
// Circular store queue. Holds entries in arrival order and exposes every slot
// plus a per-slot valid mask so the parent can search for the youngest match.
// Handshake: push is only asserted by the parent when full==0, pop only when
// empty==0; both take effect on the same rising edge and leave count unchanged.
module store_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              head,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          valid,
  output logic [$clog2(DEPTH)-1:0]  rd_ptr,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] slots;
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           count;
  logic [PW-1:0]           offset;

  // Slot storage needs no reset: only slots covered by the valid mask are read.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PW'(i) - rd_ptr;
      valid[i] = ({1'b0, offset} < count);
    end
  end

  assign entries = slots;
  assign head    = slots[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory responder: queues core stores and retires them into a
// word-addressed RAM whenever drain_ok is high. Loads forward from the
// youngest matching queued store, otherwise read the RAM.
// Optional feature macro: DONE_TRAP_EN adds a sticky done flag raised when a
// store of TRAP_VAL to TRAP_ADDR retires; without it done is constant 0.
// Handshake: a store on MemWrite is taken on the rising edge where stall==0;
// while stall==1 the core must hold MemWrite/DataAdr/WriteData unchanged.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int          DATA_W    = SB_DATA_W,
  parameter int          MEM_WORDS = SB_MEM_WORDS,
  parameter int          BUF_DEPTH = SB_BUF_DEPTH,
  parameter logic [31:0] TRAP_ADDR = DEF_TRAP_ADDR,
  parameter logic [31:0] TRAP_VAL  = DEF_TRAP_VAL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemWrite,
  input  logic [31:0]       DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  input  logic              drain_ok,
  output logic              stall,
  output logic              buf_empty,
  output logic              done
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int EW = $bits(sb_entry_t);

  logic [AW-1:0]                 idx;
  logic                          unused_adr;
  logic                          push;
  logic                          pop;
  logic                          full;
  logic                          empty;
  sb_entry_t                     din;
  sb_entry_t                     head;
  sb_entry_t                     cand;
  logic [BUF_DEPTH-1:0][EW-1:0]  entries;
  logic [BUF_DEPTH-1:0]          valid;
  logic [PW-1:0]                 rd_ptr;
  logic [PW-1:0]                 slot;
  logic [DATA_W-1:0]             ram [MEM_WORDS];

  // Byte offset bits are dropped and high address bits alias onto the RAM.
  assign idx        = DataAdr[AW+1:2];
  assign unused_adr = ^{DataAdr[31:AW+2], DataAdr[1:0]};

  // Full/empty come from registered occupancy, so a same-cycle drain never
  // lowers stall and a freshly pushed entry cannot retire on its push edge.
  assign push      = MemWrite && !full;
  assign pop       = drain_ok && !empty;
  assign stall     = full;
  assign buf_empty = empty;
  assign din       = '{idx: idx, data: WriteData};

  store_fifo #(
    .W     (EW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .head    (head),
    .entries (entries),
    .valid   (valid),
    .rd_ptr  (rd_ptr),
    .full    (full),
    .empty   (empty)
  );

  // Retire the head entry into RAM; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (pop) ram[head.idx] <= head.data;
  end

  // Scan oldest to youngest so the last match (the youngest store) wins.
  always_comb begin
    ReadData = ram[idx];
    slot     = '0;
    cand     = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      cand = sb_entry_t'(entries[slot]);
      if (valid[slot] && (cand.idx == idx)) ReadData = cand.data;
    end
  end

`ifdef DONE_TRAP_EN
  localparam logic [AW-1:0] TRAP_IDX = TRAP_ADDR[AW+1:2];

  logic done_q;

  // Sticky flag set on the edge where the trap store retires into RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else if (pop && (head.idx == TRAP_IDX) &&
                 (head.data == TRAP_VAL[DATA_W-1:0])) begin
      done_q <= 1'b1;
    end
  end

  assign done = done_q;
`else
  logic unused_trap;
  assign unused_trap = ^{TRAP_ADDR, TRAP_VAL};
  assign done        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a queue-based reference model
// checked every cycle, plus hand-computed literal checks.
module tb_dmem_store_buffer;

  logic        clk;
  logic        reset_n;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        drain_ok;
  logic        stall;
  logic        buf_empty;
  logic        done;

  int tests_run = 0;
  int fails     = 0;

  dmem_store_buffer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .drain_ok  (drain_ok),
    .stall     (stall),
    .buf_empty (buf_empty),
    .done      (done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pending stores as {word index, data}, oldest at the front.
  logic [37:0] exp_q[$];
  logic [31:0] mram [64];
  bit          mknown [64];
  bit          done_m;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      done_m = 1'b0;
    end else begin
      bit          was_full;
      logic [37:0] e;
      was_full = (exp_q.size() == 4);
      if (drain_ok && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        mram[e[37:32]]   = e[31:0];
        mknown[e[37:32]] = 1'b1;
`ifdef DONE_TRAP_EN
        if (e[37:32] == 6'd25 && e[31:0] == 32'd7) done_m = 1'b1;
`endif
      end
      if (MemWrite && !was_full) exp_q.push_back({DataAdr[7:2], WriteData});
    end
  end

  function automatic bit model_read(input logic [5:0] i, output logic [31:0] v);
    v = '0;
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (exp_q[k][37:32] == i) begin
        v = exp_q[k][31:0];
        return 1'b1;
      end
    end
    if (mknown[i]) begin
      v = mram[i];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] v;
    if (reset_n) begin
      check("cyc_stall", {31'd0, stall}, {31'd0, exp_q.size() == 4});
      check("cyc_empty", {31'd0, buf_empty}, {31'd0, exp_q.size() == 0});
      check("cyc_done", {31'd0, done}, {31'd0, done_m});
      if (model_read(DataAdr[7:2], v)) check("cyc_rdata", ReadData, v);
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs for exactly one rising edge; return just after the falling edge.
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic dr);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    drain_ok  = dr;
    @(negedge clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    MemWrite = 1'b0;
    drain_ok = 1'b0;
    DataAdr  = a;
    #1;
    check(name, ReadData, exp);
  endtask

  task automatic drain_all();
    for (int n = 0; n < 12 && !buf_empty; n++) drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("drain_bound", {31'd0, buf_empty}, 32'd1);
  endtask

  logic done_exp;

  // ---------------- stimulus ----------------
  initial begin
`ifdef DONE_TRAP_EN
    done_exp = 1'b1;
`else
    done_exp = 1'b0;
`endif
    reset_n = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; drain_ok = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_empty", {31'd0, buf_empty}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;

    // Forwarding of a single buffered store, then retire to RAM.
    drive(1'b1, 32'h60, 32'd5, 1'b0);
    peek("fwd_60", 32'h60, 32'd5);
    check("one_pending", {31'd0, buf_empty}, 32'd0);
    drive(1'b0, 32'h60, 32'd0, 1'b1);
    check("drained_60", {31'd0, buf_empty}, 32'd1);
    peek("ram_60", 32'h60, 32'd5);
    peek("alias_161", 32'h161, 32'd5);

    // Fill the buffer, hold a fifth store under stall, then free one slot.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(i * 4), 32'(10 + i), 1'b0);
    check("full_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h14, 32'd14, 1'b0);
      check("held_stall", {31'd0, stall}, 32'd1);
    end
    drive(1'b1, 32'h14, 32'd14, 1'b1);
    check("freed_stall", {31'd0, stall}, 32'd0);
    drive(1'b1, 32'h14, 32'd14, 1'b0);
    check("refull_stall", {31'd0, stall}, 32'd1);
    peek("fwd_14", 32'h14, 32'd14);
    peek("ram_00", 32'h0, 32'd10);
    peek("fwd_0c", 32'h0C, 32'd13);
    drain_all();

    // Duplicate index: youngest wins until and after retirement.
    drive(1'b1, 32'h10, 32'd1, 1'b0);
    drive(1'b1, 32'h10, 32'd2, 1'b0);
    peek("dup_young", 32'h10, 32'd2);
    drive(1'b0, 32'h10, 32'd0, 1'b1);
    peek("dup_after1", 32'h10, 32'd2);
    drain_all();
    peek("dup_ram", 32'h10, 32'd2);

    // Enqueue and drain on the same edge keeps occupancy at 2.
    drive(1'b1, 32'h20, 32'h21, 1'b0);
    drive(1'b1, 32'h24, 32'h22, 1'b0);
    drive(1'b1, 32'h28, 32'h23, 1'b1);
    peek("order_20", 32'h20, 32'h21);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("count2_a", {31'd0, buf_empty}, 32'd0);
    peek("order_24", 32'h24, 32'h22);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("count2_b", {31'd0, buf_empty}, 32'd1);
    peek("order_28", 32'h28, 32'h23);

    // Reset in the middle of a cycle discards pending stores.
    drive(1'b1, 32'h40, 32'h99, 1'b0);
    drive(1'b0, 32'h40, 32'h0, 1'b1);
    drive(1'b1, 32'h40, 32'h55, 1'b0);
    drive(1'b1, 32'h44, 32'h56, 1'b0);
    drive(1'b1, 32'h48, 32'h57, 1'b0);
    MemWrite = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_empty", {31'd0, buf_empty}, 32'd1);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h40, 32'h0, 1'b1);
    peek("midrst_ram40", 32'h40, 32'h99);
    check("midrst_still_empty", {31'd0, buf_empty}, 32'd1);

    // Trap: wrong value must not fire, the right value fires and sticks.
    drive(1'b1, 32'h64, 32'd6, 1'b0);
    drive(1'b0, 32'h64, 32'd0, 1'b1);
    check("trap_wrong_val", {31'd0, done}, 32'd0);
    drive(1'b1, 32'h64, 32'd7, 1'b0);
    check("trap_buffered", {31'd0, done}, 32'd0);
    drive(1'b0, 32'h64, 32'd0, 1'b1);
    check("trap_fire", {31'd0, done}, {31'd0, done_exp});
    drive(1'b0, 32'h0, 32'd0, 1'b0);
    drive(1'b0, 32'h0, 32'd0, 1'b0);
    check("trap_sticky", {31'd0, done}, {31'd0, done_exp});
    peek("trap_ram", 32'h64, 32'd7);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
